// File: rtl/motor_hub_multi.sv
// Multi-channel PWM hub: shared period counter, per-channel shadow/active duty with
// period-end update and optional slew limit, plus a host-write watchdog that kills all outputs.
module motor_hub_multi #(
  parameter int                   CHANNELS   = 4,
  parameter int                   CH_BITS    = 2,
  parameter int                   RESOLUTION = 12,
  parameter int                   WDOG_BITS  = 24,
  parameter logic [WDOG_BITS-1:0] WDOG_LIMIT = WDOG_BITS'(10_000_000),
  parameter int                   SLEW_STEP  = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_n,
  input  logic                  wr_en_i,
  input  logic [CH_BITS-1:0]    wr_ch_i,
  input  logic [RESOLUTION-1:0] wr_duty_i,
  output logic [CHANNELS-1:0]   out,
  output logic                  timeout,
  output logic                  period_o
);

  // state      | meaning
  // WD_RUN     | host alive, wd_cnt counting up toward WDOG_LIMIT-1
  // WD_EXPIRED | no valid write for WDOG_LIMIT cycles; duties forced to 0
  typedef enum logic {
    WD_RUN     = 1'b0,
    WD_EXPIRED = 1'b1
  } wd_state_t;

  localparam logic [RESOLUTION-1:0] CNT_MAX = '1;
  localparam logic [RESOLUTION-1:0] CNT_PRE = CNT_MAX - 1'b1;
  localparam logic [RESOLUTION:0]   STEP    = (RESOLUTION+1)'(SLEW_STEP);
  localparam logic [WDOG_BITS-1:0]  WD_LAST = WDOG_LIMIT - 1'b1;

  wd_state_t             state, state_next;
  logic [WDOG_BITS-1:0]  wd_cnt, wd_cnt_next;
  logic [RESOLUTION-1:0] cnt;
  logic [RESOLUTION-1:0] shadow   [CHANNELS];
  logic [RESOLUTION-1:0] act      [CHANNELS];
  logic [RESOLUTION-1:0] act_next [CHANNELS];
  logic                  valid;
  logic                  boundary;
  logic                  expire;

  // Extra headroom bit keeps the difference and the step sum from wrapping.
  function automatic logic [RESOLUTION-1:0] slew_toward(
    input logic [RESOLUTION-1:0] target,
    input logic [RESOLUTION-1:0] cur
  );
    logic [RESOLUTION:0] t, c, d, r;
    t = {1'b0, target};
    c = {1'b0, cur};
    if (t >= c) begin
      d = t - c;
      r = (d > STEP) ? c + STEP : t;
    end else begin
      d = c - t;
      r = (d > STEP) ? c - STEP : t;
    end
    return r[RESOLUTION-1:0];
  endfunction

  assign valid    = wr_en_i && ({{(32-CH_BITS){1'b0}}, wr_ch_i} < 32'(CHANNELS));
  assign boundary = (cnt == CNT_MAX);
  assign timeout  = (state == WD_EXPIRED);

  always_comb begin
    state_next  = state;
    wd_cnt_next = wd_cnt;
    expire      = 1'b0;
    case (state)
      WD_RUN: begin
        if (valid) begin
          wd_cnt_next = '0;
        end else if (wd_cnt == WD_LAST) begin
          expire     = 1'b1;
          state_next = WD_EXPIRED;
        end else begin
          wd_cnt_next = wd_cnt + 1'b1;
        end
      end
      WD_EXPIRED: begin
        if (valid) begin
          state_next  = WD_RUN;
          wd_cnt_next = '0;
        end
      end
      default: state_next = WD_RUN;
    endcase
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      act_next[i] = (SLEW_STEP == 0) ? shadow[i] : slew_toward(shadow[i], act[i]);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state    <= WD_RUN;
      wd_cnt   <= '0;
      cnt      <= '0;
      period_o <= 1'b0;
      out      <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        act[i]    <= '0;
      end
    end else begin
      state    <= state_next;
      wd_cnt   <= wd_cnt_next;
      cnt      <= cnt + 1'b1;
      period_o <= (cnt == CNT_PRE);
      for (int i = 0; i < CHANNELS; i++) begin
        // Expiry clears immediately, bypassing both the boundary and the slew limit.
        if (expire) begin
          shadow[i] <= '0;
          act[i]    <= '0;
        end else begin
          if (valid && (wr_ch_i == CH_BITS'(i))) shadow[i] <= wr_duty_i;
          if (boundary) act[i] <= act_next[i];
        end
        out[i] <= (cnt < act[i]);
      end
    end
  end

endmodule

// File: tb/tb_motor_hub_multi.sv
// Directed bench for motor_hub_multi: plain hub, slew-limited hub (step 3) and a
// three-channel hub for invalid-channel handling.
module tb_motor_hub_multi;

  logic       clk_i = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en   [3];
  logic [1:0] wr_ch   [3];
  logic [3:0] wr_duty [3];
  logic [3:0] out0, out1;
  logic [2:0] out2;
  logic       to0, to1, to2, po0, po1, po2;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk_i = ~clk_i;

  motor_hub_multi #(.CHANNELS(4), .CH_BITS(2), .RESOLUTION(4), .WDOG_BITS(8),
                    .WDOG_LIMIT(8'd100), .SLEW_STEP(0)) u_plain (
    .clk_i(clk_i), .reset_n(reset_n), .wr_en_i(wr_en[0]), .wr_ch_i(wr_ch[0]),
    .wr_duty_i(wr_duty[0]), .out(out0), .timeout(to0), .period_o(po0));

  motor_hub_multi #(.CHANNELS(4), .CH_BITS(2), .RESOLUTION(4), .WDOG_BITS(8),
                    .WDOG_LIMIT(8'd100), .SLEW_STEP(3)) u_slew (
    .clk_i(clk_i), .reset_n(reset_n), .wr_en_i(wr_en[1]), .wr_ch_i(wr_ch[1]),
    .wr_duty_i(wr_duty[1]), .out(out1), .timeout(to1), .period_o(po1));

  motor_hub_multi #(.CHANNELS(3), .CH_BITS(2), .RESOLUTION(4), .WDOG_BITS(8),
                    .WDOG_LIMIT(8'd100), .SLEW_STEP(0)) u_three (
    .clk_i(clk_i), .reset_n(reset_n), .wr_en_i(wr_en[2]), .wr_ch_i(wr_ch[2]),
    .wr_duty_i(wr_duty[2]), .out(out2), .timeout(to2), .period_o(po2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] out_of(input int d);
    case (d)
      0:       return out0;
      1:       return out1;
      default: return {1'b0, out2};
    endcase
  endfunction

  function automatic logic to_of(input int d);
    return (d == 0) ? to0 : (d == 1) ? to1 : to2;
  endfunction

  function automatic logic po_of(input int d);
    return (d == 0) ? po0 : (d == 1) ? po1 : po2;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input int d, input logic [1:0] ch, input logic [3:0] duty);
    wr_en[d]   = 1'b1;
    wr_ch[d]   = ch;
    wr_duty[d] = duty;
    tick();
    wr_en[d]   = 1'b0;
  endtask

  // Stop in the boundary cycle (period_o high), before its clock edge.
  task automatic wait_period(input int d);
    int n = 0;
    while (!po_of(d) && n < 40) begin
      tick();
      n++;
    end
    chk("bnd_wait", 32'(po_of(d)), 32'd1);
  endtask

  task automatic to_boundary_edge(input int d);
    wait_period(d);
    tick();
  endtask

  // Sixteen cycles starting right after a boundary edge; bit i of pat = out[ch] at cnt i.
  task automatic sample(input int d, input int ch, output logic [15:0] pat, output int oth);
    logic [3:0] o;
    pat = '0;
    oth = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      o = out_of(d);
      pat[i] = o[ch];
      for (int j = 0; j < 4; j++) if (j != ch && o[j]) oth++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      wr_en[d] = 1'b0; wr_ch[d] = '0; wr_duty[d] = '0;
    end
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  logic [15:0] pat;
  int          oth, cnt_hi, n;
  logic [3:0]  acc;
  logic [15:0] slew_up [4] = '{16'h0007, 16'h003F, 16'h01FF, 16'h03FF};
  logic [15:0] slew_dn [4] = '{16'h007F, 16'h000F, 16'h0001, 16'h0000};

  initial begin
    do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_out", 32'(out0), 32'h0);
    chk("rst_timeout", 32'(to0), 32'h0);
    chk("rst_period", 32'(po0), 32'h0);
    tick();
    reset_n = 1'b1;

    // Single channel at half duty.
    tick(); tick();
    wr(0, 2'd1, 4'd8);
    to_boundary_edge(0);
    sample(0, 1, pat, oth);
    chk("t1_ch1_pat", 32'(pat), 32'h00FF);
    chk("t1_others", 32'(oth), 32'd0);

    // Two writes inside one period: old duty held, then the last one wins.
    repeat (3) tick();
    wr(0, 2'd0, 4'd5);
    tick(); tick();
    wr(0, 2'd0, 4'd12);
    cnt_hi = 0;
    n = 0;
    while (!po0 && n < 40) begin
      tick(); n++;
      if (out0[0]) cnt_hi++;
    end
    tick();
    if (out0[0]) cnt_hi++;
    chk("t2_cur_period", 32'(cnt_hi), 32'd0);
    sample(0, 0, pat, oth);
    chk("t2_next_pat", 32'(pat), 32'h0FFF);

    // Write in the boundary cycle lands one period late.
    wait_period(0);
    wr(0, 2'd0, 4'd3);
    sample(0, 0, pat, oth);
    chk("t2_bnd_hold", 32'(pat), 32'h0FFF);
    sample(0, 0, pat, oth);
    chk("t2_bnd_new", 32'(pat), 32'h0007);

    // Watchdog expiry and recovery.
    wr(0, 2'd1, 4'd8);
    repeat (99) tick();
    chk("t3_wd_99", 32'(to0), 32'd0);
    tick();
    chk("t3_wd_100", 32'(to0), 32'd1);
    tick();
    chk("t3_out_off", 32'(out0), 32'h0);
    acc = '0;
    repeat (20) begin
      tick();
      acc |= out0;
    end
    chk("t3_out_stay_off", 32'(acc), 32'h0);
    wr(0, 2'd2, 4'd3);
    chk("t3_recover", 32'(to0), 32'd0);
    to_boundary_edge(0);
    sample(0, 2, pat, oth);
    chk("t3_ch2_pat", 32'(pat), 32'h0007);
    chk("t3_others_off", 32'(oth), 32'd0);

    // Write exactly on the expiry cycle keeps the watchdog alive.
    wr(0, 2'd0, 4'd1);
    repeat (99) tick();
    wr(0, 2'd0, 4'd2);
    chk("t4_expiry_write", 32'(to0), 32'd0);
    repeat (99) tick();
    chk("t4_restart_99", 32'(to0), 32'd0);
    tick();
    chk("t4_restart_100", 32'(to0), 32'd1);

    // Invalid channel index neither writes nor kicks the watchdog.
    do_reset();
    wr(2, 2'd0, 4'd5);
    repeat (40) tick();
    wr(2, 2'd3, 4'd9);
    repeat (58) tick();
    chk("t4_inv_99", 32'(to2), 32'd0);
    tick();
    chk("t4_inv_100", 32'(to2), 32'd1);

    // Slew-limited ramp up and down.
    do_reset();
    tick();
    wr(1, 2'd0, 4'd10);
    to_boundary_edge(1);
    for (int k = 0; k < 4; k++) begin
      sample(1, 0, pat, oth);
      chk($sformatf("t5_up%0d", k), 32'(pat), 32'(slew_up[k]));
    end
    wr(1, 2'd0, 4'd0);
    to_boundary_edge(1);
    for (int k = 0; k < 4; k++) begin
      sample(1, 0, pat, oth);
      chk($sformatf("t5_dn%0d", k), 32'(pat), 32'(slew_dn[k]));
    end

    // Asynchronous reset while an output is high.
    do_reset();
    wr(0, 2'd1, 4'd8);
    to_boundary_edge(0);
    tick();
    chk("t6_out_high", 32'(out0[1]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_out", 32'(out0), 32'h0);
    chk("t6_async_to", 32'(to0), 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    n = 0;
    acc = '0;
    while (!po0 && n < 40) begin
      tick(); n++;
      acc |= out0;
    end
    chk("t6_cnt_restart", 32'(n), 32'd15);
    chk("t6_out_zero", 32'(acc), 32'h0);
    tick();
    sample(0, 1, pat, oth);
    chk("t6_duty_zero", 32'(pat), 32'h0);
    chk("t6_others_zero", 32'(oth), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
